// File: rtl/screen_rom_reader_if.sv
// Screen ROM read port: address out from the reader, data back from the ROM.
interface screen_rom_reader_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;

    modport master (
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/screen_rom_reader.sv
// Background fetch from a sync screen ROM, 2-cycle timing-aligned RGB stream.
// Optional pixel-doubled half-resolution image: SCREEN_ROM_READER_SCALE2_EN.
module screen_rom_reader #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 12,
    parameter int IMG_W      = 1024,
    parameter int IMG_H      = 768
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [10:0]           hcount_in,
    input  logic [10:0]           vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblnk_in,
    input  logic                  vblnk_in,
    screen_rom_reader_if.master   rom,
    output logic [10:0]           hcount_out,
    output logic [10:0]           vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblnk_out,
    output logic                  vblnk_out,
    output logic [DATA_WIDTH-1:0] rgb_out
);

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
    } tim_t;

    localparam bit CFG_OK =
        (longint'(IMG_W) * longint'(IMG_H)) <= (longint'(1) << ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] line_base;
    logic [ADDR_WIDTH-1:0] base_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] h_off;
    logic [ADDR_WIDTH-1:0] step;
    logic [10:0]           v_prev;
    logic                  new_line;
    logic                  in_img;
    logic                  in_img_q;
    tim_t                  tim_in;
    tim_t                  tim_s1;

`ifdef SCREEN_ROM_READER_SCALE2_EN
    // Each stored line is shown twice: advance only when entering an even line.
    assign step     = ADDR_WIDTH'(IMG_W / 2);
    assign h_off    = ADDR_WIDTH'(hcount_in >> 1);
    assign new_line = (hcount_in == 11'd0) && (vcount_in != v_prev) &&
                      !vcount_in[0] && v_prev[0];
`else
    assign step     = ADDR_WIDTH'(IMG_W);
    assign h_off    = ADDR_WIDTH'(hcount_in);
    assign new_line = (hcount_in == 11'd0) && (vcount_in != v_prev);
`endif

    assign in_img = (32'(hcount_in) < 32'(IMG_W)) &&
                    (32'(vcount_in) < 32'(IMG_H)) &&
                    !hblnk_in && !vblnk_in;

    assign tim_in = '{h: hcount_in, v: vcount_in,
                      hs: hsync_in, vs: vsync_in,
                      hb: hblnk_in, vb: vblnk_in};

    always_comb begin
        base_nx = line_base;
        if (hcount_in == 11'd0 && vcount_in == 11'd0)
            base_nx = '0;
        else if (new_line)
            base_nx = line_base + step;
    end

    // Stage 1: address issue, image-area flag and timing capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base <= '0;
            v_prev    <= '0;
            addr_q    <= '0;
            in_img_q  <= 1'b0;
            tim_s1    <= '0;
        end else begin
            line_base <= base_nx;
            v_prev    <= vcount_in;
            in_img_q  <= in_img;
            tim_s1    <= tim_in;
            if (in_img)
                addr_q <= base_nx + h_off;
        end
    end

    // Stage 2: ROM word lands alongside the delayed timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= tim_s1.h;
            vcount_out <= tim_s1.v;
            hsync_out  <= tim_s1.hs;
            vsync_out  <= tim_s1.vs;
            hblnk_out  <= tim_s1.hb;
            vblnk_out  <= tim_s1.vb;
            rgb_out    <= in_img_q ? rom.rom_data : '0;
        end
    end

    assign rom.rom_addr = addr_q;

    always @(posedge clk) begin
        if (rst_n)
            assert (CFG_OK)
            else $error("screen_rom_reader: image exceeds ROM address space");
    end

endmodule

// File: tb/tb_screen_rom_reader.sv
// Scoreboard bench for screen_rom_reader with a combinational model ROM.
// ROM word at address a is a[11:0]; expectations come from v*W+h directly.
module tb_screen_rom_reader;

    localparam int AW    = 20;
    localparam int DW    = 12;
    localparam int IMG_W = 1024;
    localparam int IMG_H = 768;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [10:0]   hcount_in = '0;
    logic [10:0]   vcount_in = '0;
    logic          hsync_in = 1'b0;
    logic          vsync_in = 1'b0;
    logic          hblnk_in = 1'b0;
    logic          vblnk_in = 1'b0;
    logic [10:0]   hcount_out;
    logic [10:0]   vcount_out;
    logic          hsync_out;
    logic          vsync_out;
    logic          hblnk_out;
    logic          vblnk_out;
    logic [DW-1:0] rgb_out;

    always #5 clk = ~clk;

    screen_rom_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rif ();

    assign rif.rom_data = rif.rom_addr[11:0];

    screen_rom_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rom(rif.master),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    typedef struct {
        int          due;
        logic [AW-1:0] addr;
        bit          chk;
    } a_t;

    typedef struct {
        int          due;
        logic [15:0] h;
        logic [15:0] v;
        logic [3:0]  flags;
        logic [DW-1:0] rgb;
        bit          rgb_chk;
    } o_t;

    a_t qa[$];
    o_t qo[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [AW-1:0] m_last = '0;
    bit addr_ok = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input int h, input int v,
                         input bit hb = 0, input bit vb = 0,
                         input bit hs = 0, input bit vs = 0);
        bit inimg;
        @(negedge clk);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = hs;
        vsync_in  = vs;
        inimg = (h < IMG_W) && (v < IMG_H) && !hb && !vb;
        if (h == 0 && v == 0) addr_ok = 1'b1;
        if (inimg) begin
`ifdef SCREEN_ROM_READER_SCALE2_EN
            m_last = AW'((v / 2) * (IMG_W / 2) + (h / 2));
`else
            m_last = AW'(v * IMG_W + h);
`endif
        end
        qa.push_back('{due: cyc + 1, addr: m_last, chk: addr_ok});
        qo.push_back('{due: cyc + 2, h: 16'(h), v: 16'(v),
                       flags: {hs, vs, hb, vb},
                       rgb: inimg ? m_last[11:0] : '0,
                       rgb_chk: inimg ? addr_ok : 1'b1});
    endtask

    task automatic check_zero(input string name);
        logic [AW+22+4+DW-1:0] act;
        act = {rif.rom_addr, hcount_out, vcount_out,
               hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
        n_cmp++;
        if (act !== '0) begin
            n_err++;
            $display("FAIL %s: outputs %h, required all zero", name, act);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            while (qa.size() > 0 && qa[0].due <= cyc) begin
                a_t a;
                a = qa.pop_front();
                if (a.chk) begin
                    n_cmp++;
                    if (rif.rom_addr !== a.addr) begin
                        n_err++;
                        $display("FAIL rom_addr cyc %0d: got %0d required %0d",
                                 cyc, rif.rom_addr, a.addr);
                    end
                end
            end
            while (qo.size() > 0 && qo[0].due <= cyc) begin
                o_t o;
                o = qo.pop_front();
                n_cmp++;
                if ({5'd0, hcount_out} !== o.h || {5'd0, vcount_out} !== o.v ||
                    {hsync_out, vsync_out, hblnk_out, vblnk_out} !== o.flags) begin
                    n_err++;
                    $display("FAIL timing cyc %0d: got h%0d v%0d f%b required h%0d v%0d f%b",
                             cyc, hcount_out, vcount_out,
                             {hsync_out, vsync_out, hblnk_out, vblnk_out},
                             o.h, o.v, o.flags);
                end
                if (o.rgb_chk) begin
                    n_cmp++;
                    if (rgb_out !== o.rgb) begin
                        n_err++;
                        $display("FAIL rgb_out cyc %0d: got %h required %h",
                                 cyc, rgb_out, o.rgb);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_zero("reset_a");
        @(negedge clk);
        check_zero("reset_b");
        rst_n = 1'b1;

        drive(0, 0);
        drive(1, 0);
        drive(2, 0);
        for (int v = 1; v < IMG_H; v++) begin
            drive(0, v);
            if (v == 3) for (int h = 1; h <= 5; h++) drive(h, 3);
            if (v == 4) drive(6, 4);
            if (v == 5) drive(7, 5);
            if (v == 10) begin
                drive(1022, 10);
                drive(1023, 10);
                drive(1024, 10, 1);
                drive(1030, 10, 1, 0, 1);
                drive(1100, 10, 1);
            end
            if (v == 500) drive(777, 500);
        end
        drive(1023, 767);
        drive(0, 0);
        drive(3, 0);
        drive(0, 768, 0, 1, 0, 1);
        drive(1024, 768, 1, 1);
        drive(0, 0);
        for (int v = 1; v <= 100; v++) drive(0, v);
        drive(5, 100);
        drive(6, 100);

        @(negedge clk);
        #2 rst_n = 1'b0;
        qa.delete();
        qo.delete();
        m_last  = '0;
        addr_ok = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        drive(7, 100);
        for (int v = 101; v <= 110; v++) begin
            drive(0, v);
            drive(9, v);
        end
        drive(0, 768, 0, 1);
        drive(0, 0);
        drive(1, 0);
        for (int v = 1; v <= 6; v++) begin
            drive(0, v);
            drive(v * 3 + 1, v);
        end
        drive(1023, 6);
        drive(1024, 6, 1, 1);

        repeat (4) @(negedge clk);
        n_cmp++;
        if (qa.size() + qo.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, required 0", qa.size() + qo.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
